// File: rtl/fetch_unit_pkg.sv
// Shared IF-stage constants: word widths, cache geometry and fill FSM states.
package fetch_unit_pkg;
    localparam int AddrLen = 32;
    localparam int InstLen = 32;
    localparam logic ResetEnable = 1'b1;
    localparam logic [InstLen-1:0] ZERO_WORD = '0;
    localparam int ICacheIdxLen = 6;
    localparam int ICacheTagLen = 10;

    typedef enum logic [1:0] {
        IF_IDLE  = 2'd0,
        IF_FILL  = 2'd1,
        IF_DRAIN = 2'd2
    } if_state_e;
endpackage

// File: rtl/fetch_unit_icache.sv
// Direct-mapped one-word-per-line instruction cache with combinational lookup.
// Lookup is zero-latency; writes land at the edge and are visible next cycle; never stalls.
module fetch_unit_icache
    import fetch_unit_pkg::*;
#(
    parameter int IDX_W = ICacheIdxLen,
    parameter int TAG_W = ICacheTagLen
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [IDX_W-1:0]   rd_idx,
    input  logic [TAG_W-1:0]   rd_tag,
    output logic               rd_hit,
    output logic [InstLen-1:0] rd_data,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [InstLen-1:0] wr_data
);
    localparam int Entries = 1 << IDX_W;

    logic [Entries-1:0] valid_q;
    logic [Entries-1:0] valid_d;
    logic [TAG_W-1:0]   tag_q  [Entries];
    logic [InstLen-1:0] data_q [Entries];

    always_comb begin
        valid_d = valid_q;
        if (wr_en) begin
            valid_d[wr_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == ResetEnable) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag/data arrays are plain storage; only the valid bits need reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_data;
        end
    end

    assign rd_hit  = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign rd_data = data_q[rd_idx];
endmodule

// File: rtl/fetch_unit.sv
// IF stage: owns the PC, looks up the icache and refills misses one byte at a time.
// Hits present with zero latency; a miss holds the PC and raises if_stall_req until the line lands.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int ICACHE_IDX_W = ICacheIdxLen,
    parameter int ICACHE_TAG_W = ICacheTagLen
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         stall,
    input  logic               br_flag,
    input  logic [AddrLen-1:0] br_target,
    output logic               mem_rd_req,
    output logic [AddrLen-1:0] mem_rd_addr,
    input  logic               mem_rd_ack,
    input  logic [7:0]         mem_rd_data,
    output logic               if_stall_req,
    output logic [AddrLen-1:0] if_pc,
    output logic [InstLen-1:0] if_inst
);
    if_state_e          state_q, state_d;
    logic [AddrLen-1:0] pc_q, pc_d;
    logic [AddrLen-1:0] fill_addr_q, fill_addr_d;
    logic [1:0]         byte_cnt_q, byte_cnt_d;
    logic               drain_q, drain_d;
    logic [23:0]        line_q, line_d;

    logic                    hit;
    logic [InstLen-1:0]      rdata;
    logic                    cache_we;
    logic [ICACHE_IDX_W-1:0] rd_idx;
    logic [ICACHE_TAG_W-1:0] rd_tag;
    logic [ICACHE_IDX_W-1:0] wr_idx;
    logic [ICACHE_TAG_W-1:0] wr_tag;
    logic                    unused_bits;

    assign rd_idx      = pc_q[ICACHE_IDX_W+1:2];
    assign rd_tag      = pc_q[ICACHE_IDX_W+2 +: ICACHE_TAG_W];
    assign wr_idx      = fill_addr_q[ICACHE_IDX_W+1:2];
    assign wr_tag      = fill_addr_q[ICACHE_IDX_W+2 +: ICACHE_TAG_W];
    assign unused_bits = ^{br_target[1:0], stall[5:1]};

    fetch_unit_icache #(
        .IDX_W (ICACHE_IDX_W),
        .TAG_W (ICACHE_TAG_W)
    ) u_icache (
        .clk     (clk),
        .rst     (rst),
        .rd_idx  (rd_idx),
        .rd_tag  (rd_tag),
        .rd_hit  (hit),
        .rd_data (rdata),
        .wr_en   (cache_we),
        .wr_idx  (wr_idx),
        .wr_tag  (wr_tag),
        .wr_data ({mem_rd_data, line_q})
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        fill_addr_d = fill_addr_q;
        byte_cnt_d  = byte_cnt_q;
        drain_d     = drain_q;
        line_d      = line_q;
        cache_we    = 1'b0;

        if_stall_req = !((state_q == IF_IDLE) && hit);
        if_inst      = if_stall_req ? ZERO_WORD : rdata;
        if_pc        = pc_q;
        mem_rd_req   = (state_q != IF_IDLE);
        mem_rd_addr  = mem_rd_req ? (fill_addr_q + {30'b0, byte_cnt_q}) : '0;

        if (br_flag) begin
            pc_d = {br_target[AddrLen-1:2], 2'b00};
        end else if (!stall[0] && !if_stall_req) begin
            pc_d = pc_q + 32'd4;
        end

        case (state_q)
            IF_IDLE: begin
                // A miss on a PC that is being redirected away is not worth fetching.
                if (if_stall_req && !br_flag) begin
                    fill_addr_d = pc_q;
                    byte_cnt_d  = 2'd0;
                    drain_d     = 1'b0;
                    state_d     = IF_FILL;
                end
            end
            IF_FILL: begin
                if (mem_rd_ack) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    case (byte_cnt_q)
                        2'd0:    line_d[7:0]   = mem_rd_data;
                        2'd1:    line_d[15:8]  = mem_rd_data;
                        2'd2:    line_d[23:16] = mem_rd_data;
                        default: begin
                            cache_we = 1'b1;
                            state_d  = IF_IDLE;
                        end
                    endcase
                end
                if (br_flag && !(mem_rd_ack && byte_cnt_q == 2'd3)) begin
                    drain_d = 1'b1;
                    state_d = IF_DRAIN;
                end
            end
            IF_DRAIN: begin
                // The controller cannot cancel, so wait out the in-flight byte and drop it.
                if (mem_rd_ack) begin
                    drain_d = 1'b0;
                    state_d = IF_IDLE;
                end
            end
            default: state_d = IF_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == ResetEnable) begin
            state_q     <= IF_IDLE;
            pc_q        <= '0;
            fill_addr_q <= '0;
            byte_cnt_q  <= 2'd0;
            drain_q     <= 1'b0;
            line_q      <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            fill_addr_q <= fill_addr_d;
            byte_cnt_q  <= byte_cnt_d;
            drain_q     <= drain_d;
            line_q      <= line_d;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, corner-case sequences, random run vs model.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        br_flag;
    logic [31:0] br_target;
    logic        mem_rd_req;
    logic [31:0] mem_rd_addr;
    logic        mem_rd_ack;
    logic [7:0]  mem_rd_data;
    logic        if_stall_req;
    logic [31:0] if_pc;
    logic [31:0] if_inst;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .br_flag      (br_flag),
        .br_target    (br_target),
        .mem_rd_req   (mem_rd_req),
        .mem_rd_addr  (mem_rd_addr),
        .mem_rd_ack   (mem_rd_ack),
        .mem_rd_data  (mem_rd_data),
        .if_stall_req (if_stall_req),
        .if_pc        (if_pc),
        .if_inst      (if_inst)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Backing memory contents: the cold-start word at 0, a hash elsewhere.
    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [7:0] boot [4];
        boot[0] = 8'h13; boot[1] = 8'h05; boot[2] = 8'h10; boot[3] = 8'h00;
        if (a < 32'd4) return boot[a[1:0]];
        return (a[7:0] * 8'd37) ^ a[15:8] ^ 8'h5a;
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
    endfunction

    // Reference model: a lookup table of cached words plus "fill in progress" bookkeeping.
    bit [63:0]   m_valid = '0;
    logic [9:0]  m_tag  [64];
    logic [31:0] m_word [64];
    logic [31:0] m_pc = '0;
    bit          m_busy = 1'b0;
    bit          m_drain = 1'b0;
    logic [31:0] m_faddr = '0;
    int          m_got = 0;
    logic [7:0]  m_bytes [4];

    bit          e_stall;
    logic [31:0] e_inst;
    bit          e_req;
    logic [31:0] e_addr;

    task automatic model_eval();
        int idx;
        bit hit;
        idx     = int'(m_pc[7:2]);
        hit     = !m_busy && m_valid[idx] && (m_tag[idx] == m_pc[17:8]);
        e_stall = !hit;
        e_inst  = hit ? m_word[idx] : 32'h0;
        e_req   = m_busy;
        e_addr  = m_busy ? m_faddr + 32'(m_got) : 32'h0;
    endtask

    task automatic model_step(input bit ack, input logic [7:0] dat);
        int fidx;
        if (rst) begin
            m_pc = '0; m_valid = '0; m_busy = 1'b0; m_drain = 1'b0; m_got = 0;
            return;
        end
        if (!m_busy) begin
            if (e_stall && !br_flag) begin
                m_busy = 1'b1; m_drain = 1'b0; m_faddr = m_pc; m_got = 0;
            end
        end else if (m_drain) begin
            if (ack) begin m_busy = 1'b0; m_drain = 1'b0; end
        end else begin
            if (ack) begin
                m_bytes[m_got] = dat;
                m_got++;
                if (m_got == 4) begin
                    fidx = int'(m_faddr[7:2]);
                    m_valid[fidx] = 1'b1;
                    m_tag[fidx]   = m_faddr[17:8];
                    m_word[fidx]  = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
                    m_busy = 1'b0;
                end
            end
            if (m_busy && br_flag) m_drain = 1'b1;
        end
        if (br_flag) m_pc = br_target & 32'hffff_fffc;
        else if (!stall[0] && !e_stall) m_pc = m_pc + 32'd4;
    endtask

    typedef struct {
        bit          br;
        logic [31:0] tgt;
        logic [5:0]  stl;
        bit          ack;
        logic [7:0]  dat;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_stall;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
    } vec_t;

    function automatic vec_t v(input bit br, input logic [31:0] tgt, input logic [5:0] stl,
                               input bit ack, input logic [7:0] dat, input bit er,
                               input logic [31:0] ea, input bit es, input logic [31:0] ep,
                               input logic [31:0] ei);
        vec_t r;
        r.br = br; r.tgt = tgt; r.stl = stl; r.ack = ack; r.dat = dat;
        r.e_req = er; r.e_addr = ea; r.e_stall = es; r.e_pc = ep; r.e_inst = ei;
        return r;
    endfunction

    bit   chk_en = 1'b0;
    bit   tbl_active = 1'b0;
    vec_t cur;
    bit   auto_ack = 1'b0;
    int   lat = 1;
    int   waited = 0;

    task automatic cycle();
        logic       req_before;
        logic       ack_now;
        logic [7:0] dat_now;
        if (auto_ack) begin
            mem_rd_ack  = mem_rd_req && (waited >= lat);
            mem_rd_data = mem_rd_ack ? mem_byte(mem_rd_addr) : 8'($urandom);
        end
        #1;
        model_eval();
        if (chk_en) begin
            chk("if_pc", if_pc, m_pc);
            chk("if_stall_req", 32'(if_stall_req), 32'(e_stall));
            chk("if_inst", if_inst, e_inst);
            chk("mem_rd_req", 32'(mem_rd_req), 32'(e_req));
            if (e_req) chk("mem_rd_addr", mem_rd_addr, e_addr);
        end
        if (tbl_active) begin
            chk("vec_pc", if_pc, cur.e_pc);
            chk("vec_stall_req", 32'(if_stall_req), 32'(cur.e_stall));
            chk("vec_inst", if_inst, cur.e_inst);
            chk("vec_req", 32'(mem_rd_req), 32'(cur.e_req));
            chk("vec_addr", mem_rd_addr, cur.e_addr);
        end
        req_before = mem_rd_req;
        ack_now    = mem_rd_ack;
        dat_now    = mem_rd_data;
        @(posedge clk);
        model_step(ack_now, dat_now);
        if (rst || !req_before || ack_now) waited = 0;
        else waited++;
        @(negedge clk);
    endtask

    vec_t tbl [18];

    initial begin
        // Cold start, redirect-to-hit, stall[0] hold on a hit, then redirect to 0x103.
        tbl[0]  = v(0, 0, 0, 0, 8'h00, 0, 0, 1, 0, 0);
        tbl[1]  = v(0, 0, 0, 0, 8'h00, 1, 0, 1, 0, 0);
        tbl[2]  = v(0, 0, 0, 1, 8'h13, 1, 0, 1, 0, 0);
        tbl[3]  = v(0, 0, 0, 0, 8'h00, 1, 1, 1, 0, 0);
        tbl[4]  = v(0, 0, 0, 1, 8'h05, 1, 1, 1, 0, 0);
        tbl[5]  = v(0, 0, 0, 0, 8'h00, 1, 2, 1, 0, 0);
        tbl[6]  = v(0, 0, 0, 1, 8'h10, 1, 2, 1, 0, 0);
        tbl[7]  = v(0, 0, 0, 0, 8'h00, 1, 3, 1, 0, 0);
        tbl[8]  = v(0, 0, 0, 1, 8'h00, 1, 3, 1, 0, 0);
        tbl[9]  = v(0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 32'h0010_0513);
        tbl[10] = v(1, 0, 0, 0, 8'h00, 0, 0, 1, 4, 0);
        tbl[11] = v(0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 32'h0010_0513);
        tbl[12] = v(1, 0, 0, 0, 8'h00, 0, 0, 1, 4, 0);
        tbl[13] = v(0, 0, 6'h01, 0, 8'h00, 0, 0, 0, 0, 32'h0010_0513);
        tbl[14] = v(0, 0, 6'h01, 0, 8'h00, 0, 0, 0, 0, 32'h0010_0513);
        tbl[15] = v(0, 0, 6'h3f, 0, 8'h00, 0, 0, 0, 0, 32'h0010_0513);
        tbl[16] = v(0, 0, 6'h1e, 0, 8'h00, 0, 0, 0, 0, 32'h0010_0513);
        tbl[17] = v(1, 32'h103, 0, 0, 8'h00, 0, 0, 1, 4, 0);

        rst = 1'b1; stall = '0; br_flag = 1'b0; br_target = '0;
        mem_rd_ack = 1'b0; mem_rd_data = '0;
        @(negedge clk);
        cycle();
        chk_en = 1'b1;
        cycle();
        chk("reset_addr", mem_rd_addr, 32'h0);
        chk("reset_stall_req", 32'(if_stall_req), 32'h1);
        rst = 1'b0;

        tbl_active = 1'b1;
        for (int i = 0; i < 18; i++) begin
            cur = tbl[i];
            br_flag = cur.br; br_target = cur.tgt; stall = cur.stl;
            mem_rd_ack = cur.ack; mem_rd_data = cur.dat;
            cycle();
        end
        tbl_active = 1'b0;
        br_flag = 1'b0; stall = '0; mem_rd_ack = 1'b0;
        chk("redirect_pc", if_pc, 32'h100);

        // Redirect during fill: third byte request is drained, nothing is written.
        auto_ack = 1'b1; lat = 1; waited = 0;
        repeat (5) cycle();
        br_flag = 1'b1; br_target = 32'h103;
        cycle();
        br_flag = 1'b0;
        chk("t3_drain_req", 32'(mem_rd_req), 32'h1);
        chk("t3_drain_addr", mem_rd_addr, 32'h102);
        cycle();
        chk("t3_req_drop", 32'(mem_rd_req), 32'h0);
        chk("t3_pc", if_pc, 32'h100);
        chk("t3_no_write", 32'(if_stall_req), 32'h1);

        // Redirect coincident with the 4th ack still installs the line.
        repeat (8) cycle();
        br_flag = 1'b1; br_target = 32'h300;
        cycle();
        chk("t4_pc", if_pc, 32'h300);
        chk("t4_req", 32'(mem_rd_req), 32'h0);
        br_target = 32'h100;
        cycle();
        br_flag = 1'b0;
        chk("t4_hit", 32'(if_stall_req), 32'h0);
        chk("t4_inst", if_inst, word_at(32'h100));

        // A miss under stall[0] still fills, and the PC does not move afterwards.
        stall = 6'h01; br_flag = 1'b1; br_target = 32'h400;
        cycle();
        br_flag = 1'b0;
        repeat (10) cycle();
        chk("t5_pc", if_pc, 32'h400);
        chk("t5_fill_hit", 32'(if_stall_req), 32'h0);
        chk("t5_inst", if_inst, word_at(32'h400));
        stall = '0;

        // Reset mid-fill drops the request and invalidates everything.
        br_flag = 1'b1; br_target = 32'h500;
        cycle();
        br_flag = 1'b0;
        repeat (3) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("t6_req", 32'(mem_rd_req), 32'h0);
        chk("t6_pc", if_pc, 32'h0);
        chk("t6_stall_req", 32'(if_stall_req), 32'h1);
        br_flag = 1'b1; br_target = 32'h100;
        cycle();
        br_flag = 1'b0;
        chk("t6_pc2", if_pc, 32'h100);
        chk("t6_miss", 32'(if_stall_req), 32'h1);

        // Random traffic in a small address window so lines alias and re-hit.
        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(0, 299) == 0);
            br_flag   = ($urandom_range(0, 7) == 0);
            br_target = 32'($urandom_range(0, 2047));
            stall     = 6'($urandom);
            stall[0]  = ($urandom_range(0, 3) == 0);
            if (!mem_rd_req) lat = int'($urandom_range(0, 2));
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
